// File: rtl/wb_cmd_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the
// byte-command to Wishbone bridge.
package wb_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    localparam logic [7:0] RSP_OK   = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS_REQ,
        BUS_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Byte-stream command decoder driving a single pipelined Wishbone B4
// transfer per command, then streaming a response back byte by byte.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  cmd_data_i,
    input  logic        cmd_valid_i,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        overrun_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_write_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rsp_shift_q;
    logic [1:0]  rsp_left_q;
    logic [15:0] tmo_cnt_q;
    logic        overrun_q;

    logic        last_byte;
    logic        ack_ok;
    logic        tmo_hit;
    logic        op_ok;

    // An ack only counts once our strobe has been (or is being) accepted.
    assign last_byte = cmd_valid_i && (byte_cnt_q == 2'd3);
    assign ack_ok    = wb_ack_i && (((state_q == BUS_REQ) && !wb_stall_i) ||
                                    (state_q == BUS_WAIT));
    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
    assign op_ok     = (cmd_data_i == OP_WRITE) || (cmd_data_i == OP_READ);

    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign rsp_data_o = rsp_shift_q[7:0];
    assign overrun_o  = overrun_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived bus/response outputs.
    always_comb begin
        state_d     = state_q;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        wb_we_o     = 1'b0;
        wb_sel_o    = '0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = op_ok ? ADDR : RESP;
                end
            end
            ADDR: begin
                if (last_byte) begin
                    state_d = is_write_q ? DATA : BUS_REQ;
                end
            end
            DATA: begin
                if (last_byte) begin
                    state_d = BUS_REQ;
                end
            end
            BUS_REQ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = is_write_q;
                wb_sel_o = 4'hF;
                if (ack_ok || tmo_hit) begin
                    state_d = RESP;
                end else if (!wb_stall_i) begin
                    state_d = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                wb_cyc_o = 1'b1;
                wb_we_o  = is_write_q;
                wb_sel_o = 4'hF;
                if (ack_ok || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i && (rsp_left_q == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command shift registers, timeout counter and response serializer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_write_q  <= 1'b0;
            byte_cnt_q  <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_shift_q <= '0;
            rsp_left_q  <= '0;
            tmo_cnt_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= cmd_valid_i &&
                         ((state_q == BUS_REQ) || (state_q == BUS_WAIT) || (state_q == RESP));
            case (state_q)
                IDLE: begin
                    byte_cnt_q <= '0;
                    if (cmd_valid_i) begin
                        is_write_q <= (cmd_data_i == OP_WRITE);
                        if (!op_ok) begin
                            rsp_shift_q <= {24'h0, RSP_ERR};
                            rsp_left_q  <= '0;
                        end
                    end
                end
                // Little-endian fields: shifting in from the top leaves the
                // first byte in bits 7:0 after four strobes.
                ADDR: begin
                    tmo_cnt_q <= '0;
                    if (cmd_valid_i) begin
                        adr_q      <= {cmd_data_i, adr_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                DATA: begin
                    tmo_cnt_q <= '0;
                    if (cmd_valid_i) begin
                        dat_q      <= {cmd_data_i, dat_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                BUS_REQ, BUS_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (ack_ok) begin
                        rsp_shift_q <= is_write_q ? {24'h0, RSP_OK} : wb_dat_i;
                        rsp_left_q  <= is_write_q ? 2'd0 : 2'd3;
                    end else if (tmo_hit) begin
                        rsp_shift_q <= {24'h0, RSP_ERR};
                        rsp_left_q  <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready_i && (rsp_left_q != 2'd0)) begin
                        rsp_shift_q <= {8'h0, rsp_shift_q[31:8]};
                        rsp_left_q  <= rsp_left_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: stimulus pushes expected Wishbone
// transfers, cycle lengths and response bytes; monitors pop and compare.
module tb_wb_cmd_master;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  cmd_data_i;
    logic        cmd_valid_i;
    logic [7:0]  rsp_data_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        overrun_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_stall_i;
    logic        slv_ack;
    logic        stray_ack;
    logic        ack_mux;

    assign ack_mux = slv_ack | stray_ack;

    always #5 clk_i = ~clk_i;

    wb_cmd_master #(.TIMEOUT(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_data_i  (cmd_data_i),
        .cmd_valid_i (cmd_valid_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .overrun_o   (overrun_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_stb_o    (wb_stb_o),
        .wb_ack_i    (ack_mux),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stall_i  (wb_stall_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } wb_exp_t;

    wb_exp_t    exp_wb[$];
    int         exp_len[$];
    logic [7:0] exp_rsp[$];

    int checks = 0;
    int errors = 0;
    int exp_acc = 0;
    int acc_cnt = 0;
    int ov_cnt = 0;

    // slave configuration
    int stall_left = 0;
    int ack_delay = 1;
    bit no_ack = 0;
    int ack_cnt = 0;
    bit pending = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Wishbone slave model: stall count, then ack a fixed delay after accept.
    initial begin
        wb_stall_i = 1'b0;
        slv_ack    = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            slv_ack    = 1'b0;
            wb_stall_i = 1'b0;
            if (!rst_ni || !wb_cyc_o) begin
                pending = 0;
            end else if (wb_stb_o) begin
                if (stall_left > 0) begin
                    wb_stall_i = 1'b1;
                    stall_left--;
                end else if (ack_delay == 0) begin
                    slv_ack = !no_ack;
                end else begin
                    pending = 1;
                    ack_cnt = ack_delay;
                end
            end else if (pending) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    slv_ack = !no_ack;
                    pending = 0;
                end
            end
        end
    end

    // Monitor: bus protocol, accepted transfers, cycle length, response stream.
    logic        prev_stall_stb = 1'b0;
    logic [31:0] prev_adr;
    logic        prev_we;
    logic        prev_cyc = 1'b0;
    int          cyc_len = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  held;
    logic        prev_ov = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall_stb = 1'b0;
            prev_cyc       = 1'b0;
            cyc_len        = 0;
            prev_hold      = 1'b0;
            prev_ov        = 1'b0;
        end else begin
            if (wb_stb_o && !wb_cyc_o) chk("stb_without_cyc", 32'd1, 32'd0);
            if (prev_stall_stb) begin
                chk("adr_stable_stall", wb_adr_o, prev_adr);
                chk("we_stable_stall", {31'd0, wb_we_o}, {31'd0, prev_we});
            end
            prev_stall_stb = wb_stb_o && wb_stall_i;
            prev_adr       = wb_adr_o;
            prev_we        = wb_we_o;

            if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
                acc_cnt++;
                if (exp_wb.size() == 0) begin
                    chk("unexpected_stb", 32'd1, 32'd0);
                end else begin
                    wb_exp_t e;
                    e = exp_wb.pop_front();
                    chk("wb_adr", wb_adr_o, e.adr);
                    chk("wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
                    chk("wb_sel", {28'd0, wb_sel_o}, 32'hF);
                    if (e.we) chk("wb_dat", wb_dat_o, e.dat);
                end
            end

            if (wb_cyc_o) begin
                cyc_len++;
            end else if (prev_cyc) begin
                if (exp_len.size() == 0) chk("unexpected_cyc", 32'd1, 32'd0);
                else chk("cyc_len", cyc_len, exp_len.pop_front());
                cyc_len = 0;
            end
            prev_cyc = wb_cyc_o;

            if (prev_hold && rsp_valid_o) chk("rsp_hold", {24'd0, rsp_data_o}, {24'd0, held});
            prev_hold = rsp_valid_o && !rsp_ready_i;
            held      = rsp_data_o;

            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_rsp.size() == 0) chk("unexpected_rsp", {24'd0, rsp_data_o}, 32'hFFFF_FFFF);
                else chk("rsp_byte", {24'd0, rsp_data_o}, {24'd0, exp_rsp.pop_front()});
            end

            if (overrun_o) begin
                ov_cnt++;
                if (prev_ov) chk("overrun_width", 32'd2, 32'd1);
            end
            prev_ov = overrun_o;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        cmd_data_i  = b;
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // bytes[7:0] goes out first
    task automatic send_cmd(input int n, input logic [71:0] bytes, input bit expect_stb);
        for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8]);
        if (expect_stb) chk("stb_latency", {31'd0, wb_stb_o}, 32'd1);
    endtask

    task automatic exp_txn(input logic [31:0] adr, input logic [31:0] dat,
                           input logic we, input int len);
        wb_exp_t e;
        e.adr = adr;
        e.dat = dat;
        e.we  = we;
        exp_wb.push_back(e);
        exp_len.push_back(len);
        exp_acc++;
    endtask

    task automatic exp_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_rsp.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_done(input string name);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk_i);
            #1;
            if (exp_rsp.size() == 0 && !rsp_valid_o && !wb_cyc_o) done = 1;
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    int acc_before;
    bit seen;

    initial begin
        rst_ni      = 1'b0;
        cmd_data_i  = '0;
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        wb_dat_i    = '0;
        stray_ack   = 1'b0;
        #2;
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data_o}, 32'd0);
        chk("rst_overrun", {31'd0, overrun_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // write, ack two cycles after accept
        ack_delay = 2;
        exp_txn(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 3);
        exp_rsp.push_back(8'hA5);
        send_cmd(9, 72'hDE_AD_BE_EF_00_00_00_10_01, 1'b1);
        wait_done("write");

        // stray ack while idle must be ignored
        stray_ack = 1'b1;
        @(posedge clk_i);
        #1;
        stray_ack = 1'b0;

        // read, LSB first
        ack_delay = 1;
        wb_dat_i  = 32'h1234_5678;
        exp_txn(32'h0000_0004, 32'h0, 1'b0, 2);
        exp_word(32'h1234_5678);
        send_cmd(5, 72'h00_00_00_04_02, 1'b1);
        wait_done("read");

        // read with three stalled cycles
        stall_left = 3;
        wb_dat_i   = 32'hCAFE_F00D;
        exp_txn(32'h0000_0100, 32'h0, 1'b0, 5);
        exp_word(32'hCAFE_F00D);
        send_cmd(5, 72'h00_00_01_00_02, 1'b1);
        wait_done("read_stall");

        // write acked in the same cycle as the accept
        ack_delay = 0;
        exp_txn(32'h0000_0020, 32'h1122_3344, 1'b1, 1);
        exp_rsp.push_back(8'hA5);
        send_cmd(9, 72'h11_22_33_44_00_00_00_20_01, 1'b1);
        wait_done("write_ack0");

        // no ack: cycle dropped after TIMEOUT cycles, error response
        ack_delay = 1;
        no_ack    = 1;
        exp_txn(32'h0000_0008, 32'h0, 1'b0, 8);
        exp_rsp.push_back(8'hEE);
        send_cmd(5, 72'h00_00_00_08_02, 1'b1);
        wait_done("timeout");
        no_ack = 0;

        // bad opcode: error response, no bus activity
        acc_before = acc_cnt;
        seen = 0;
        exp_rsp.push_back(8'hEE);
        send_cmd(1, 72'h7F, 1'b0);
        for (int i = 0; i < 20 && (exp_rsp.size() != 0 || rsp_valid_o); i++) begin
            if (wb_cyc_o) seen = 1;
            @(posedge clk_i);
            #1;
        end
        wait_done("bad_op");
        chk("bad_op_no_stb", acc_cnt, acc_before);
        chk("bad_op_no_cyc", {31'd0, seen}, 32'd0);

        // backpressured read response with a byte injected during RESP
        rsp_ready_i = 1'b0;
        wb_dat_i    = 32'hA1B2_C3D4;
        exp_txn(32'h0000_000C, 32'h0, 1'b0, 2);
        exp_word(32'hA1B2_C3D4);
        send_cmd(5, 72'h00_00_00_0C_02, 1'b1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (rsp_valid_o) seen = 1;
            else begin
                @(posedge clk_i);
                #1;
            end
        end
        chk("resp_reached", {31'd0, seen}, 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        send_byte(8'h01);
        repeat (2) @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        wait_done("read_bp");

        // decoding intact after the dropped byte
        exp_txn(32'h0000_0030, 32'h0403_0201, 1'b1, 2);
        exp_rsp.push_back(8'hA5);
        send_cmd(9, 72'h04_03_02_01_00_00_00_30_01, 1'b1);
        wait_done("write_after_ovr");

        // reset mid-transfer while stalled
        stall_left = 100;
        send_cmd(5, 72'h00_00_00_40_02, 1'b1);
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("async_rst_stb", {31'd0, wb_stb_o}, 32'd0);
        @(posedge clk_i);
        #1;
        stall_left = 0;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // normal read after reset
        wb_dat_i = 32'h0BAD_F00D;
        exp_txn(32'h0000_0004, 32'h0, 1'b0, 2);
        exp_word(32'h0BAD_F00D);
        send_cmd(5, 72'h00_00_00_04_02, 1'b1);
        wait_done("read_after_rst");

        repeat (3) @(posedge clk_i);
        chk("accepted_stbs", acc_cnt, exp_acc);
        chk("overrun_pulses", ov_cnt, 1);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        chk("wb_queue_empty", exp_wb.size(), 0);
        chk("len_queue_empty", exp_len.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
